// File: rtl/bus_drvr_fifo_if.sv
// Per-driver bus endpoint: host-fed TX FIFO toward the arbiter and an
// ID-filtered RX FIFO from the bus toward the host.

module bus_drvr_fifo_if_fifo #(
  parameter int bits  = 32,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [bits-1:0]          wdata,
  input  logic                     rd,
  output logic [bits-1:0]          rdata,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [bits-1:0] mem [depth];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            empty;
  logic            full;
  logic            rd_ok;
  logic            wr_ok;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(depth));
  assign rd_ok = rd && !empty;
  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr_ok = wr && (!full || rd_ok);

  assign rdata = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

module bus_drvr_fifo_if #(
  parameter int         bits      = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_wr,
  input  logic [bits-1:0]        tx_data,
  output logic                   tx_full,
  output logic [$clog2(depth):0] tx_count,
  output logic                   pndng,
  output logic [bits-1:0]        D_pop,
  input  logic                   pop,
  input  logic                   push,
  input  logic [bits-1:0]        D_push,
  input  logic                   rx_rd,
  output logic [bits-1:0]        rx_data,
  output logic                   rx_empty,
  output logic                   rx_drop,
  output logic                   rx_ovf
);

  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0] rx_count;
  logic [7:0]    rx_dest;
  logic          rx_match;
  logic          rx_full;
  logic          rx_drop_reg;
  logic          rx_ovf_reg;

  bus_drvr_fifo_if_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .count (tx_count)
  );

  assign tx_full = (tx_count == CW'(depth));
  assign pndng   = (tx_count != '0);

  assign rx_dest  = D_push[bits-1 -: 8];
  assign rx_match = push && ((rx_dest == id) || (rx_dest == broadcast));

  bus_drvr_fifo_if_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_match),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .count (rx_count)
  );

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(depth));

  // A matching packet is lost only when RX is full and the host does not free a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_drop_reg <= 1'b0;
      rx_ovf_reg  <= 1'b0;
    end else begin
      rx_drop_reg <= rx_match && rx_full && !rx_rd;
      if (rx_match && rx_full && !rx_rd) begin
        rx_ovf_reg <= 1'b1;
      end
    end
  end

  assign rx_drop = rx_drop_reg;
  assign rx_ovf  = rx_ovf_reg;

endmodule
